spi_flash_prog: RTL and testbench

SPI_FLASH_PROG -- requirements
Module: spi_flash_prog

---
 rtl/spi_flash_prog.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_flash_prog.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_prog.sv
// spi_flash_prog: programs one 256-byte flash page through a buffered SPI master using WREN/WEAR/WREN/PP, then polls RDSR.
// Optional macro SPI_FLASH_PROG_TIMEOUT_EN bounds the status polling at POLL_MAX polls and reports a timeout on error.
module spi_flash_prog #(
    parameter logic [19:0] POLL_MAX = 20'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] page_addr,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  flash_wr_nBytes,
    output logic [8:0]  flash_rd_nBytes,
    output logic        flash_cmd_strobe,
    output logic        wbuf_wr_en,
    output logic [6:0]  wbuf_wr_addr,
    output logic [31:0] wbuf_data_in,
    output logic        rbuf_rd_en,
    output logic [6:0]  rbuf_rd_addr,
    input  logic [31:0] rbuf_data_out,
    input  logic        spi_ss
);

    typedef enum logic [2:0] {IDLE, WREN1, WEAR, WREN2, LOAD, PP, POLL, DONE} state_t;
    typedef enum logic [2:0] {WRITE, STROBE, WAIT_LOW, WAIT_HIGH, DATA, RD_REQ, RD_CHECK} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [23:0] addr_q, addr_d;
    logic [6:0]  wordCnt_q, wordCnt_d;
    logic [31:0] cmdWord;
    logic [8:0]  wrBytes;
    logic [8:0]  rdBytes;

`ifdef SPI_FLASH_PROG_TIMEOUT_EN
    logic [19:0] pollCnt_q, pollCnt_d;
    logic [19:0] pollInc;
    logic        errFlag_q, errFlag_d;

    assign pollInc = (pollCnt_q == 20'hFFFFF) ? pollCnt_q : pollCnt_q + 20'd1;
`endif

    // Only bit 24 of the status word (WIP) and the page-aligned address bits matter.
    logic unusedBits;
    assign unusedBits = ^{rbuf_data_out[31:25], rbuf_data_out[23:0], page_addr[7:0], POLL_MAX};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            phase_q   <= WRITE;
            addr_q    <= '0;
            wordCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            wordCnt_q <= wordCnt_d;
        end
    end

`ifdef SPI_FLASH_PROG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pollCnt_q <= '0;
            errFlag_q <= 1'b0;
        end else begin
            pollCnt_q <= pollCnt_d;
            errFlag_q <= errFlag_d;
        end
    end
`endif

    // Per-command wbuf word and byte counts; addr_q holds page_addr[31:8].
    always_comb begin
        cmdWord = 32'h0600_0000;
        wrBytes = 9'd1;
        rdBytes = 9'd0;
        case (state_q)
            WEAR: begin
                cmdWord = {8'hC5, addr_q[23:16], 16'h0000};
                wrBytes = 9'd2;
            end
            PP: begin
                cmdWord = {8'h02, addr_q[15:0], 8'h00};
                wrBytes = 9'd260;
            end
            POLL: begin
                cmdWord = 32'h0500_0000;
                rdBytes = 9'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        addr_d           = addr_q;
        wordCnt_d        = wordCnt_q;
        busy             = (state_q != IDLE);
        data_ready       = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        flash_wr_nBytes  = '0;
        flash_rd_nBytes  = '0;
        flash_cmd_strobe = 1'b0;
        wbuf_wr_en       = 1'b0;
        wbuf_wr_addr     = '0;
        wbuf_data_in     = '0;
        rbuf_rd_en       = 1'b0;
        rbuf_rd_addr     = '0;
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
        pollCnt_d        = pollCnt_q;
        errFlag_d        = errFlag_q;
`endif

        case (state_q)
            IDLE: begin
                phase_d = WRITE;
                if (start) begin
                    state_d   = WREN1;
                    addr_d    = page_addr[31:8];
                    wordCnt_d = '0;
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
                    pollCnt_d = '0;
                    errFlag_d = 1'b0;
`endif
                end
            end

            // Header first, then stream words land at wbuf addresses 1..64.
            LOAD: begin
                if (phase_q == WRITE) begin
                    wbuf_wr_en   = 1'b1;
                    wbuf_data_in = {8'h02, addr_q[15:0], 8'h00};
                    phase_d      = DATA;
                end else begin
                    data_ready = 1'b1;
                    if (data_valid) begin
                        wbuf_wr_en   = 1'b1;
                        wbuf_wr_addr = wordCnt_q + 7'd1;
                        wbuf_data_in = data_in;
                        wordCnt_d    = wordCnt_q + 7'd1;
                        if (wordCnt_q == 7'd63) begin
                            state_d = PP;
                            phase_d = STROBE;
                        end
                    end
                end
            end

            DONE: begin
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
                done  = !errFlag_q;
                error = errFlag_q;
`else
                done  = 1'b1;
`endif
                state_d = IDLE;
                phase_d = WRITE;
            end

            default: begin
                case (phase_q)
                    WRITE: begin
                        wbuf_wr_en   = 1'b1;
                        wbuf_data_in = cmdWord;
                        phase_d      = STROBE;
                    end
                    STROBE: begin
                        flash_cmd_strobe = 1'b1;
                        flash_wr_nBytes  = wrBytes;
                        flash_rd_nBytes  = rdBytes;
                        phase_d          = WAIT_LOW;
                    end
                    WAIT_LOW: begin
                        flash_wr_nBytes = wrBytes;
                        flash_rd_nBytes = rdBytes;
                        if (!spi_ss) phase_d = WAIT_HIGH;
                    end
                    WAIT_HIGH: begin
                        flash_wr_nBytes = wrBytes;
                        flash_rd_nBytes = rdBytes;
                        if (spi_ss) begin
                            phase_d = WRITE;
                            case (state_q)
                                WREN1:   state_d = WEAR;
                                WEAR:    state_d = WREN2;
                                WREN2:   state_d = LOAD;
                                PP:      state_d = POLL;
                                default: phase_d = RD_REQ;
                            endcase
                        end
                    end
                    RD_REQ: begin
                        rbuf_rd_en = 1'b1;
                        phase_d    = RD_CHECK;
                    end
                    RD_CHECK: begin
                        if (rbuf_data_out[24]) begin
                            phase_d = WRITE;
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
                            pollCnt_d = pollInc;
                            if (pollInc >= POLL_MAX) begin
                                state_d   = DONE;
                                errFlag_d = 1'b1;
                            end
`endif
                        end else begin
                            state_d = DONE;
                        end
                    end
                    default: phase_d = WRITE;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_prog.sv
// tb_spi_flash_prog: scoreboard bench for spi_flash_prog with an SPI-idle model and a WIP status model.
// Define SPI_FLASH_PROG_TIMEOUT_EN to build the DUT with POLL_MAX=4 and add the stuck-WIP scenario.
`timescale 1ns/1ps
module tb_spi_flash_prog;

`ifdef SPI_FLASH_PROG_TIMEOUT_EN
    localparam logic [19:0] TB_POLL_MAX = 20'd4;
`else
    localparam logic [19:0] TB_POLL_MAX = 20'd1000000;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  wr;
        logic [8:0]  rd;
        logic [31:0] word;
    } evT;

    localparam logic [1:0] EV_STROBE = 2'd0;
    localparam logic [1:0] EV_DONE   = 2'd1;
    localparam logic [1:0] EV_ERROR  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] page_addr;
    logic        data_valid;
    logic [31:0] data_in;
    logic        data_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  flash_wr_nBytes;
    logic [8:0]  flash_rd_nBytes;
    logic        flash_cmd_strobe;
    logic        wbuf_wr_en;
    logic [6:0]  wbuf_wr_addr;
    logic [31:0] wbuf_data_in;
    logic        rbuf_rd_en;
    logic [6:0]  rbuf_rd_addr;
    logic [31:0] rbuf_data_out = 32'h0;
    logic        spi_ss = 1'b1;

    int          checkCount = 0;
    int          errorCount = 0;
    evT          expQ[$];
    logic [31:0] expWords [0:63];
    logic [31:0] wbufMem [0:127];
    int          rdsrReads = 0;
    int          wipBase = 0;
    int          wipTarget = 0;
    bit          abortSeq = 1'b0;
    bit          busyDropPending = 1'b0;
    evT          monAct;
    evT          monExp;

    always #5 clk = ~clk;

    spi_flash_prog #(.POLL_MAX(TB_POLL_MAX)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .page_addr        (page_addr),
        .data_valid       (data_valid),
        .data_in          (data_in),
        .data_ready       (data_ready),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .flash_wr_nBytes  (flash_wr_nBytes),
        .flash_rd_nBytes  (flash_rd_nBytes),
        .flash_cmd_strobe (flash_cmd_strobe),
        .wbuf_wr_en       (wbuf_wr_en),
        .wbuf_wr_addr     (wbuf_wr_addr),
        .wbuf_data_in     (wbuf_data_in),
        .rbuf_rd_en       (rbuf_rd_en),
        .rbuf_rd_addr     (rbuf_rd_addr),
        .rbuf_data_out    (rbuf_data_out),
        .spi_ss           (spi_ss)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] outVec();
        return 64'({busy, done, error, data_ready, flash_cmd_strobe, wbuf_wr_en, rbuf_rd_en,
                    flash_wr_nBytes, flash_rd_nBytes});
    endfunction

    function automatic void pushEv(input logic [1:0] kind, input logic [8:0] wr, input logic [8:0] rd,
                                   input logic [31:0] word);
        evT e;
        e.kind = kind;
        e.wr   = wr;
        e.rd   = rd;
        e.word = word;
        expQ.push_back(e);
    endfunction

    // Status register model: one-cycle read latency, WIP=1 for the first wipTarget reads of a run.
    always @(posedge clk) begin
        if (rbuf_rd_en) begin
            rbuf_data_out <= ((rdsrReads - wipBase) < wipTarget) ? 32'h0100_0000 : 32'hFE00_00FF;
            rdsrReads     <= rdsrReads + 1;
        end else begin
            rbuf_data_out <= 32'h0;
        end
    end

    // SPI interface model: goes busy two cycles after a strobe, idle again three cycles later.
    initial begin
        logic [8:0] savedWr;
        logic [8:0] savedRd;
        forever begin
            @(negedge clk);
            if (flash_cmd_strobe) begin
                savedWr = flash_wr_nBytes;
                savedRd = flash_rd_nBytes;
                repeat (2) @(negedge clk);
                spi_ss = 1'b0;
                repeat (3) @(negedge clk);
                if (!abortSeq) begin
                    checkOutput("wrBytesHeld", 64'(flash_wr_nBytes), 64'(savedWr));
                    checkOutput("rdBytesHeld", 64'(flash_rd_nBytes), 64'(savedRd));
                end
                spi_ss = 1'b1;
            end
        end
    end

    // Monitor: mirrors wbuf writes and scores every strobe/done/error against the expected queue.
    always @(negedge clk) begin
        if (wbuf_wr_en) wbufMem[wbuf_wr_addr] = wbuf_data_in;
        if (rbuf_rd_en) checkOutput("rbufAddr", 64'(rbuf_rd_addr), 64'd0);
        if (busyDropPending) begin
            checkOutput("busyAfterEnd", 64'(busy), 64'd0);
            busyDropPending = 1'b0;
        end
        if (flash_cmd_strobe || done || error) begin
            monAct.kind = flash_cmd_strobe ? EV_STROBE : (done ? EV_DONE : EV_ERROR);
            monAct.wr   = flash_cmd_strobe ? flash_wr_nBytes : 9'd0;
            monAct.rd   = flash_cmd_strobe ? flash_rd_nBytes : 9'd0;
            monAct.word = flash_cmd_strobe ? wbufMem[0] : 32'h0;
            checkOutput("eventExpected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                checkOutput("eventKind", 64'(monAct.kind), 64'(monExp.kind));
                checkOutput("wrBytes", 64'(monAct.wr), 64'(monExp.wr));
                checkOutput("rdBytes", 64'(monAct.rd), 64'(monExp.rd));
                checkOutput("cmdWord", 64'(monAct.word), 64'(monExp.word));
                if (monExp.kind == EV_STROBE && monExp.wr == 9'd260) begin
                    for (int i = 1; i <= 64; i++)
                        checkOutput("ppWord", 64'(wbufMem[i]), 64'(expWords[i-1]));
                end
                if (!flash_cmd_strobe) begin
                    checkOutput("busyAtEnd", 64'(busy), 64'd1);
                    busyDropPending = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] salt, input int wipCount,
                                 input bit gapped, input bit pokeDuringPP, input bit resetDuringPP);
        int  k;
        int  cyc;
        int  nPolls;
        bit  accepted;
        bit  timedOut;

        abortSeq = 1'b0;
        for (int i = 0; i < 128; i++) wbufMem[i] = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++)
            expWords[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} ^ salt;
        wipBase   = rdsrReads;
        wipTarget = wipCount;

        pushEv(EV_STROBE, 9'd1,   9'd0, 32'h0600_0000);
        pushEv(EV_STROBE, 9'd2,   9'd0, {8'hC5, addr[31:24], 16'h0000});
        pushEv(EV_STROBE, 9'd1,   9'd0, 32'h0600_0000);
        pushEv(EV_STROBE, 9'd260, 9'd0, {8'h02, addr[23:8], 8'h00});
        if (!resetDuringPP) begin
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
            timedOut = (wipCount >= int'(TB_POLL_MAX));
`else
            timedOut = 1'b0;
`endif
            nPolls = timedOut ? int'(TB_POLL_MAX) : wipCount + 1;
            for (int p = 0; p < nPolls; p++) pushEv(EV_STROBE, 9'd1, 9'd1, 32'h0500_0000);
            pushEv(timedOut ? EV_ERROR : EV_DONE, 9'd0, 9'd0, 32'h0);
        end

        @(negedge clk);
        start     = 1'b1;
        page_addr = addr;
        @(negedge clk);
        start     = 1'b0;
        page_addr = ~addr;
        checkOutput("busyAfterStart", 64'(busy), 64'd1);

        k   = 0;
        cyc = 0;
        while (k < 64 && cyc < 4000) begin
            data_valid = !(gapped && (cyc % 2 == 1));
            data_in    = data_valid ? expWords[k] : (32'hBADD_A7A0 ^ 32'(k));
            accepted   = data_valid && data_ready;
            @(negedge clk);
            cyc++;
            if (accepted) k++;
        end
        data_valid = 1'b0;
        checkOutput("loadWords", 64'(k), 64'd64);

        if (pokeDuringPP || resetDuringPP) begin
            cyc = 0;
            while (!(flash_cmd_strobe && flash_wr_nBytes == 9'd260) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            checkOutput("ppStrobeSeen", 64'(flash_cmd_strobe), 64'd1);
            if (pokeDuringPP) begin
                start     = 1'b1;
                page_addr = 32'hFFFF_FF00;
                @(negedge clk);
                start     = 1'b0;
            end else begin
                @(negedge clk);
                reset    = 1'b0;
                abortSeq = 1'b1;
                @(negedge clk);
                checkOutput("abortOutputs", outVec(), 64'd0);
                reset = 1'b1;
                checkOutput("abortQueue", 64'(expQ.size()), 64'd0);
                repeat (20) @(negedge clk);
                return;
            end
        end

        cyc = 0;
        while (expQ.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        page_addr  = 32'h0;
        data_valid = 1'b0;
        data_in    = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", outVec(), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idleOutputs", outVec(), 64'd0);

        $display("[TB] page program, three busy polls");
        applyStimulus(32'h0123_4500, 32'h0, 3, 1'b0, 1'b0, 1'b0);
        $display("[TB] gapped data stream");
        applyStimulus(32'h8A5C_3100, 32'h5A5A_0F0F, 0, 1'b1, 1'b0, 1'b0);
        $display("[TB] start pulsed during PP");
        applyStimulus(32'hA5C3_7E00, 32'h1357_9BDF, 1, 1'b0, 1'b1, 1'b0);
        $display("[TB] reset during PP wait");
        applyStimulus(32'h0BAD_F000, 32'hC001_D00D, 0, 1'b0, 1'b0, 1'b1);
        $display("[TB] fresh start after abort");
        applyStimulus(32'h7654_3200, 32'h2468_ACE0, 2, 1'b1, 1'b0, 1'b0);
`ifdef SPI_FLASH_PROG_TIMEOUT_EN
        $display("[TB] stuck WIP timeout");
        applyStimulus(32'h0F0F_0F00, 32'h1111_2222, 1000, 1'b0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
